avalon_peripheral_decoder: RTL
==============================

AVALON_PERIPHERAL_DECODER -- requirements
Module: avalon_peripheral_decoder

Interface
REQ-001 Parameter: REG_BASE, 0, byte base of register window (32 bytes, 0..31).
REQ-002 Parameter: MEM_BASE, 1024, byte base of memory window (1024 bytes, 1024..2047).
REQ-003 Parameter: TIMEOUT_CYCLES, 16'd1000, maximum WAIT cycles before error response.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: reset  input  1  asynchronous active-high reset.
REQ-007 Port: avs_address  input  32  master byte address.
REQ-008 Port: avs_read / avs_write  input  1 each  master command strobes.
REQ-009 Port: avs_writedata  input  32  master write data.
REQ-010 Port: avs_waitrequest  output  1  command not accepted this cycle.
REQ-011 Port: avs_readdata  output  32  read response data.
REQ-012 Port: avs_readdatavalid / avs_error  output  1 each  response strobe / error flag.
REQ-013 Port: reg_read, reg_write  output  1; reg_address  output  3  (address[4:2]); reg_data_in  output  32.
REQ-014 Port: reg_read_valid  input  1; reg_data_out  input  32.
REQ-015 Port: mem_read, mem_write  output  1; mem_address  output  8  (address[9:2]); mem_data_in  output  32.
REQ-016 Port: mem_read_valid  input  1; mem_data_out  input  32.
REQ-017 Port: irq_in  input  1; avs_irq  output  1  (irq_in registered, 1-cycle latency).

Function
REQ-018 FSM states SHALL be IDLE, REG_WAIT, MEM_WAIT, ERR_RESP.
REQ-019 avs_waitrequest SHALL be 0 in IDLE and 1 in all other states.
REQ-020 In IDLE, a command hitting a window SHALL drive the matching read/write strobe combinationally for exactly that cycle, with address slice and reg/mem_data_in = avs_writedata.
REQ-021 Accepted mapped write: stays IDLE, no response generated.
REQ-022 Accepted mapped read: IDLE->REG_WAIT or MEM_WAIT next edge.
REQ-023 In x_WAIT, matching x_read_valid SHALL capture x_data_out; next cycle avs_readdatavalid=1 for one cycle, avs_error=0; state returns to IDLE.
REQ-024 Valids from the non-selected target, or any valid in IDLE, SHALL be ignored.
REQ-025 Unmapped read, or avs_read and avs_write both high in IDLE: no strobes; ->ERR_RESP; next cycle avs_readdatavalid=1, avs_readdata=32'hDEADBEEF, avs_error=1; ->IDLE.
REQ-026 Unmapped write: silently dropped, no strobes, no response.
REQ-027 Minimum mapped-read latency: accept cycle N, slave valid N+1, avs_readdatavalid N+2.
REQ-028 avs_readdata SHALL hold its last value when avs_readdatavalid=0; avs_error SHALL be 0 except on the error response cycle.

Reset
REQ-029 Reset SHALL force IDLE, timeout counter 0, avs_readdata 0, avs_readdatavalid 0, avs_error 0, avs_irq 0.
REQ-030 Reset mid-read SHALL discard the pending read; no response is ever issued for it.

Configuration
REQ-031 With DECODER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on WAIT entry and increment each WAIT cycle; on reaching TIMEOUT_CYCLES without valid: ->ERR_RESP (0xDEADBEEF, avs_error=1).
REQ-032 Without DECODER_TIMEOUT_EN, no counter SHALL exist; WAIT states SHALL persist until the matching valid or reset.

Verification
REQ-033 Write addr 0x400, data 0x400 -> mem_write=1, mem_address=0, mem_data_in=0x400 same cycle; no avs_readdatavalid.
REQ-034 Read 0x404; mem_read_valid with 0x404 one cycle later -> avs_readdatavalid=1, avs_readdata=0x404 the cycle after.
REQ-035 Read 0x10 -> reg_read=1, reg_address=4; avs_waitrequest=1 until response; a write issued meanwhile is held until IDLE.
REQ-036 Read 0x100 -> no strobes; 2 cycles after accept: avs_readdata=0xDEADBEEF, avs_error=1.
REQ-037 DECODER_TIMEOUT_EN, TIMEOUT_CYCLES=16, read 0x404 with no valid -> error response after 16 WAIT cycles; a late mem_read_valid is ignored.
REQ-038 Assert reset during MEM_WAIT, then mem_read_valid -> state IDLE, no avs_readdatavalid, outputs 0.

Source files
------------

// File: rtl/avalon_peripheral_decoder.sv
// ---------------------------------------------------------------------------
// avalon_peripheral_decoder
//
// Avalon-MM slave that splits a 32-bit byte-addressed master port into two
// downstream targets: a 32-byte register window and a 1 KiB memory window.
// Writes are forwarded in the accept cycle and never answered. Reads are
// forwarded in the accept cycle and answered one cycle after the target's
// read-valid. Unmapped reads, and cycles with read and write both asserted,
// get a 0xDEADBEEF error reply. Unmapped writes are silently dropped.
//
// Optional feature (compile-time macro DECODER_TIMEOUT_EN):
//   A 16-bit wait counter aborts a read with the error reply when the target
//   stays silent for TIMEOUT_CYCLES cycles. Without the macro a waiting read
//   lasts until the target answers or reset is asserted.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   avs_*                 Avalon-MM slave side (address, read, write,
//                         writedata, waitrequest, readdata, readdatavalid,
//                         error, irq)
//   reg_*                 register target: read/write strobes, word address
//                         (address[4:2]), write data, read valid/data
//   mem_*                 memory target: read/write strobes, word address
//                         (address[9:2]), write data, read valid/data
//   irq_in                interrupt from the peripheral, re-timed to avs_irq
// ---------------------------------------------------------------------------
module avalon_peripheral_decoder #(
  parameter logic [31:0] REG_BASE       = 32'd0,
  parameter logic [31:0] MEM_BASE       = 32'd1024,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  // Avalon-MM slave
  input  logic [31:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_error,
  // register target
  output logic        reg_read,
  output logic        reg_write,
  output logic [2:0]  reg_address,
  output logic [31:0] reg_data_in,
  input  logic        reg_read_valid,
  input  logic [31:0] reg_data_out,
  // memory target
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic        mem_read_valid,
  input  logic [31:0] mem_data_out,
  // interrupt
  input  logic        irq_in,
  output logic        avs_irq
);

  localparam logic [31:0] REG_SPAN = 32'd32;
  localparam logic [31:0] MEM_SPAN = 32'd1024;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REG_WAIT = 2'd1,
    MEM_WAIT = 2'd2,
    ERR_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdv_q, rdv_d;
  logic        err_q, err_d;
  logic        irq_q;

  logic [31:0] reg_off, mem_off;
  logic        reg_hit, mem_hit;

  // Window membership by offset: the subtraction wraps for addresses below
  // the base, so a single unsigned compare covers both window edges.
  assign reg_off = avs_address - REG_BASE;
  assign mem_off = avs_address - MEM_BASE;
  assign reg_hit = (reg_off < REG_SPAN);
  assign mem_hit = (mem_off < MEM_SPAN);

  // Address slices and write data go straight through; only the strobes
  // qualify a transfer.
  assign reg_address = avs_address[4:2];
  assign reg_data_in = avs_writedata;
  assign mem_address = avs_address[9:2];
  assign mem_data_in = avs_writedata;

  assign avs_waitrequest   = (state_q != IDLE);
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rdv_q;
  assign avs_error         = err_q;
  assign avs_irq           = irq_q;

`ifdef DECODER_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d, tmo_inc;
  logic        tmo_hit;

  assign tmo_inc = tmo_q + 16'd1;
  // Fires on the TIMEOUT_CYCLES-th silent wait cycle.
  assign tmo_hit = (tmo_inc == TIMEOUT_CYCLES);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // -------------------------------------------------------------------------
  // Next-state, target strobes and response generation
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    rdv_d     = 1'b0;
    err_d     = 1'b0;
    reg_read  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
`ifdef DECODER_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (avs_read && avs_write) begin
          // Ambiguous command: nothing reaches the targets.
          state_d = ERR_RESP;
        end else if (avs_read) begin
`ifdef DECODER_TIMEOUT_EN
          tmo_d = 16'd0;
`endif
          if (reg_hit) begin
            reg_read = 1'b1;
            state_d  = REG_WAIT;
          end else if (mem_hit) begin
            mem_read = 1'b1;
            state_d  = MEM_WAIT;
          end else begin
            state_d  = ERR_RESP;
          end
        end else if (avs_write) begin
          // Writes never leave IDLE; unmapped ones simply vanish.
          if (reg_hit) begin
            reg_write = 1'b1;
          end else if (mem_hit) begin
            mem_write = 1'b1;
          end
        end
      end

      REG_WAIT: begin
        // Only the selected target may complete the read.
        if (reg_read_valid) begin
          rdata_d = reg_data_out;
          rdv_d   = 1'b1;
          state_d = IDLE;
        end
`ifdef DECODER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ERR_RESP;
        end else begin
          tmo_d = tmo_inc;
        end
`endif
      end

      MEM_WAIT: begin
        if (mem_read_valid) begin
          rdata_d = mem_data_out;
          rdv_d   = 1'b1;
          state_d = IDLE;
        end
`ifdef DECODER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ERR_RESP;
        end else begin
          tmo_d = tmo_inc;
        end
`endif
      end

      ERR_RESP: begin
        rdata_d = ERR_WORD;
        rdv_d   = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and registered response outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
      rdv_q   <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      err_q   <= err_d;
      irq_q   <= irq_in;
    end
  end

`ifdef DECODER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= 16'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

endmodule
